// File: rtl/snake_pixel_gen.sv
// -----------------------------------------------------------------------------
// snake_pixel_gen
//
// Pixel source for the 640x480 VGA timing stage. The Snake board is stored as
// a 40x30 grid of 2-bit cell codes, and each cell covers 16x16 pixels. The
// scan position is mapped to a cell, that cell is read from block RAM, and the
// code is turned into a 12-bit RGB colour. The latency from pos_x_i/pos_y_i to
// new_data_o is 3 clk. The pixel position advances every 4 clk, so the
// pipeline completes within one pixel period.
//
// Optional build macro: GRID_LINES_EN
//   When defined, an empty cell draws a C_GRID line on its first pixel row
//   and its first pixel column.
//   When undefined, empty cells are solid C_BG.
//
// Ports:
//   clk            100 MHz system clock
//   rst_n          asynchronous active-low reset
//   pos_x_i[9:0]   pixel column from the timing stage (>= 640 is blanking)
//   pos_y_i[9:0]   pixel row from the timing stage (>= 480 is blanking)
//   frame_tick_i   one-clk pulse per frame; drives the food blink
//   wr_en_i        board write strobe
//   wr_col_i[5:0]  write cell column, 0..COLS-1
//   wr_row_i[4:0]  write cell row, 0..ROWS-1
//   wr_code_i[1:0] cell code: 0 empty, 1 body, 2 head, 3 food
//   clear_req_i    one-clk request to sweep the whole board to empty
//   busy_o         high while the clear sweep runs
//   new_data_o     registered RGB {r[3:0], g[3:0], b[3:0]}
// -----------------------------------------------------------------------------
module snake_pixel_gen #(
  parameter int          COLS         = 40,
  parameter int          ROWS         = 30,
  parameter int          CELL_SHIFT   = 4,
  parameter int          BLINK_FRAMES = 15,
  parameter logic [11:0] C_BG         = 12'h000,
  parameter logic [11:0] C_BODY       = 12'h0F0,
  parameter logic [11:0] C_HEAD       = 12'hFF0,
  parameter logic [11:0] C_FOOD       = 12'hF00
`ifdef GRID_LINES_EN
  ,
  parameter logic [11:0] C_GRID       = 12'h222
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pos_x_i,
  input  logic [9:0]  pos_y_i,
  input  logic        frame_tick_i,
  input  logic        wr_en_i,
  input  logic [5:0]  wr_col_i,
  input  logic [4:0]  wr_row_i,
  input  logic [1:0]  wr_code_i,
  input  logic        clear_req_i,
  output logic        busy_o,
  output logic [11:0] new_data_o
);

  localparam int          CELLS      = COLS * ROWS;
  localparam logic [5:0]  COLS_MAX   = 6'(COLS);
  localparam logic [4:0]  ROWS_MAX   = 5'(ROWS);
  localparam logic [10:0] LAST_ADDR  = 11'(CELLS - 1);
  localparam int          BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // row*40 + col, built from shifts so no multiplier is inferred.
  function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return 11'({row, 5'b00000}) + 11'({row, 3'b000}) + 11'(col);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage S0: register the cell coordinates and the range flag
  // ---------------------------------------------------------------------------
  logic [5:0] col_q;
  logic [4:0] row_q;
  logic       in_range0_q;
  logic       v0_q;
`ifdef GRID_LINES_EN
  logic [CELL_SHIFT-1:0] lowx0_q, lowy0_q;
  logic [CELL_SHIFT-1:0] lowx1_q, lowy1_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      in_range0_q <= 1'b0;
      v0_q        <= 1'b0;
`ifdef GRID_LINES_EN
      lowx0_q     <= '0;
      lowy0_q     <= '0;
`endif
    end else begin
      col_q       <= 6'(pos_x_i >> CELL_SHIFT);
      row_q       <= 5'(pos_y_i >> CELL_SHIFT);
      in_range0_q <= (pos_x_i < 10'd640) && (pos_y_i < 10'd480);
      v0_q        <= 1'b1;
`ifdef GRID_LINES_EN
      lowx0_q     <= pos_x_i[CELL_SHIFT-1:0];
      lowy0_q     <= pos_y_i[CELL_SHIFT-1:0];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage S1: board RAM, one read port and one write port
  // ---------------------------------------------------------------------------
  logic [1:0]  mem [0:CELLS-1];
  logic [1:0]  rd_code_q;
  logic [10:0] rd_addr;
  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [1:0]  ram_wdata;
  logic        in_range1_q;
  logic        v1_q;

  // Out-of-range scan positions would address past the board. They read cell 0,
  // and the range flag masks the result.
  assign rd_addr = in_range0_q ? cell_addr(row_q, col_q) : 11'd0;

  // Not reset: the board contents survive reset. The read samples the old
  // word when it collides with a write (read-first).
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    rd_code_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_range1_q <= 1'b0;
      v1_q        <= 1'b0;
`ifdef GRID_LINES_EN
      lowx1_q     <= '0;
      lowy1_q     <= '0;
`endif
    end else begin
      in_range1_q <= in_range0_q;
      v1_q        <= v0_q;
`ifdef GRID_LINES_EN
      lowx1_q     <= lowx0_q;
      lowy1_q     <= lowy0_q;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Food blink: the phase toggles every BLINK_FRAMES frame ticks
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_tick_i) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q   <= blink_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage S2: colour map
  // ---------------------------------------------------------------------------
  logic [11:0] color_d;
  logic [11:0] new_data_q;

  always_comb begin
    color_d = C_BG;
    if (in_range1_q) begin
      case (rd_code_q)
        2'd1:    color_d = C_BODY;
        2'd2:    color_d = C_HEAD;
        2'd3:    color_d = blink_phase_q ? C_BG : C_FOOD;
        default: begin
`ifdef GRID_LINES_EN
          if ((lowx1_q == '0) || (lowy1_q == '0)) begin
            color_d = C_GRID;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_data_q <= 12'h000;
    end else if (v1_q) begin
      new_data_q <= color_d;
    end
  end

  assign new_data_o = new_data_q;

  // ---------------------------------------------------------------------------
  // Write arbitration and the clear-sweep FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [10:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = 1'b0;
    ram_waddr  = cell_addr(wr_row_i, wr_col_i);
    ram_wdata  = wr_code_i;
    case (state_q)
      IDLE: begin
        // A clear request takes priority over a write in the same clk.
        if (clear_req_i) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else if (wr_en_i && (wr_col_i < COLS_MAX) && (wr_row_i < ROWS_MAX)) begin
          ram_we = 1'b1;
        end
      end
      CLEAR: begin
        // The sweep owns the write port, so game writes are dropped.
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = 2'd0;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == CLEAR);

endmodule

// File: tb/tb_snake_pixel_gen.sv
// -----------------------------------------------------------------------------
// Testbench for snake_pixel_gen. A reference board model and a blink model
// supply the expected colours. Each probe pushes its expected colour onto a
// queue and pops it when the DUT output for that position is due.
// -----------------------------------------------------------------------------
module tb_snake_pixel_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pos_x, pos_y;
  logic        frame_tick, wr_en, clear_req;
  logic [5:0]  wr_col;
  logic [4:0]  wr_row;
  logic [1:0]  wr_code;
  logic        busy;
  logic [11:0] new_data;

  int          n_cmp = 0;
  int          n_err = 0;

  logic [11:0] exp_q [$];
  logic [1:0]  board_m [0:1199];
  int          blink_cnt_m   = 0;
  logic        blink_phase_m = 1'b0;

  always #5 clk = ~clk;

  snake_pixel_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pos_x_i      (pos_x),
    .pos_y_i      (pos_y),
    .frame_tick_i (frame_tick),
    .wr_en_i      (wr_en),
    .wr_col_i     (wr_col),
    .wr_row_i     (wr_row),
    .wr_code_i    (wr_code),
    .clear_req_i  (clear_req),
    .busy_o       (busy),
    .new_data_o   (new_data)
  );

  function automatic logic [11:0] model_colour(input int x, input int y);
    logic [1:0] code;
    if (x >= 640 || y >= 480) return 12'h000;
    code = board_m[(y / 16) * 40 + (x / 16)];
    case (code)
      2'd1: return 12'h0F0;
      2'd2: return 12'hFF0;
      2'd3: return blink_phase_m ? 12'h000 : 12'hF00;
      default: begin
`ifdef GRID_LINES_EN
        if ((x % 16) == 0 || (y % 16) == 0) return 12'h222;
`endif
        return 12'h000;
      end
    endcase
  endfunction

  // Drive a scan position now and queue its expected colour.
  task automatic push_probe(input int x, input int y);
    pos_x = 10'(x);
    pos_y = 10'(y);
    exp_q.push_back(model_colour(x, y));
  endtask

  // One-clk write strobe. The model accepts only in-range cells; the bench
  // never writes while a sweep runs, except inside test_clear.
  task automatic wr_cell(input int c, input int r, input int code);
    @(negedge clk);
    wr_en = 1'b1; wr_col = 6'(c); wr_row = 5'(r); wr_code = 2'(code);
    @(negedge clk);
    wr_en = 1'b0;
    if (c < 40 && r < 30) board_m[r * 40 + c] = 2'(code);
  endtask

  task automatic test_reset();
    logic [11:0] e;
    rst_n = 1'b0;
    pos_x = '0; pos_y = '0;
    frame_tick = 1'b0; wr_en = 1'b0; clear_req = 1'b0;
    wr_col = '0; wr_row = '0; wr_code = '0;
    repeat (3) @(negedge clk);
    e = 12'h000;
    n_cmp++;
    if (new_data !== e) begin
      n_err++; $display("FAIL reset_new_data got %h expected %h", new_data, e);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b expected 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: new_data=%h busy=%b", new_data, busy);
  endtask

  task automatic test_clear();
    int cnt;
    logic [11:0] e;
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    cnt = 0;
    for (int t = 0; t < 5000; t++) begin
      if (busy === 1'b1) cnt++;
      else if (cnt > 0) break;
      // A repeated request and a write to an already-cleared cell, both
      // issued mid-sweep; each must be ignored.
      clear_req = (cnt == 100);
      wr_en     = (cnt == 600);
      wr_col = 6'd5; wr_row = 5'd3; wr_code = 2'd2;
      @(negedge clk);
    end
    clear_req = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (cnt != 1200) begin
      n_err++; $display("FAIL clear_busy_clks got %0d expected 1200", cnt);
    end
    $display("clear: busy high for %0d clk", cnt);
    for (int i = 0; i < 1200; i++) board_m[i] = 2'd0;
    // Stream every cell centre back to back and check that the board is empty.
    for (int i = 0; i < 1203; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (new_data !== e) begin
          n_err++; $display("FAIL clear_scan cell=%0d got %h expected %h", i - 3, new_data, e);
        end
      end
      if (i < 1200) push_probe((i % 40) * 16 + 8, (i / 40) * 16 + 8);
    end
    $display("clear: scanned 1200 cells");
  endtask

  task automatic test_write_latency();
    logic [11:0] e, old;
    wr_cell(5, 3, 2);
    @(negedge clk); push_probe(79, 50);
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); old = e;
    n_cmp++;
    if (new_data !== e) begin
      n_err++; $display("FAIL col4_empty got %h expected %h", new_data, e);
    end
    @(negedge clk); push_probe(85, 50);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (new_data !== old) begin
        n_err++; $display("FAIL latency_early clk=%0d got %h expected %h", k, new_data, old);
      end
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (new_data !== e) begin
      n_err++; $display("FAIL head_3clk got %h expected %h", new_data, e);
    end
    $display("latency: head at (85,50) -> %h", new_data);
  endtask

  task automatic test_corners();
    logic [11:0] e;
    int xs [4] = '{639, 640, 10, 8};
    int ys [4] = '{479, 10, 1000, 24};
    wr_cell(39, 29, 1);
    wr_cell(40, 0, 1);   // column out of range: dropped
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); push_probe(xs[k], ys[k]);
      repeat (3) @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (new_data !== e) begin
        n_err++; $display("FAIL corner (%0d,%0d) got %h expected %h", xs[k], ys[k], new_data, e);
      end
      $display("corner: (%0d,%0d) -> %h", xs[k], ys[k], new_data);
    end
  endtask

  task automatic test_blink();
    logic [11:0] e;
    wr_cell(0, 0, 3);
    for (int t = 0; t <= 30; t++) begin
      if (t > 0) begin
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        if (blink_cnt_m == 14) begin
          blink_cnt_m = 0; blink_phase_m = ~blink_phase_m;
        end else begin
          blink_cnt_m++;
        end
      end
      @(negedge clk); push_probe(3, 3);
      repeat (3) @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (new_data !== e) begin
        n_err++; $display("FAIL blink tick=%0d got %h expected %h", t, new_data, e);
      end
      $display("blink: tick %0d -> %h", t, new_data);
    end
  endtask

  task automatic test_grid();
    logic [11:0] e;
    int xs [3] = '{16, 17, 16};
    for (int k = 0; k < 3; k++) begin
      if (k == 2) wr_cell(1, 0, 1);
      @(negedge clk); push_probe(xs[k], 5);
      repeat (3) @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (new_data !== e) begin
        n_err++; $display("FAIL grid (%0d,5) step=%0d got %h expected %h", xs[k], k, new_data, e);
      end
      $display("grid: (%0d,5) -> %h", xs[k], new_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL midclear_busy got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL async_reset_busy got %b expected 0", busy);
    end
    n_cmp++;
    if (new_data !== 12'h000) begin
      n_err++; $display("FAIL async_reset_data got %h expected 000", new_data);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_busy got %b expected 0", busy);
    end
    $display("reset mid-clear: busy=%b", busy);
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_latency();
    test_corners();
    test_blink();
    test_grid();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snake_pixel_gen.md
Name: snake_pixel_gen

Overview:
- Upstream pixel source for the 640x480 VGA timing stage.
- Holds the Snake game board as a 40x30 grid of 16x16-pixel cells in on-chip RAM, written by the game logic.
- Maps the scan position from the timing stage to a cell, and returns that cell's 12-bit RGB colour as new_data.
- Runs on the 100 MHz system clock. The pixel position advances once every 4 clk, so the 3-clk pipeline fits inside one pixel period.

Parameters:
- COLS, 40, board width in cells
- ROWS, 30, board height in cells
- CELL_SHIFT, 4, log2 of cell size in pixels (16 px)
- BLINK_FRAMES, 15, frames per food blink half-period
- C_BG, 12'h000, background / empty cell colour
- C_BODY, 12'h0F0, snake body colour
- C_HEAD, 12'hFF0, snake head colour
- C_FOOD, 12'hF00, food colour
- C_GRID, 12'h222, grid line colour (optional feature only)

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- pos_x  in  10  current pixel column from timing stage; values >= 640 are blanking/underflow
- pos_y  in  10  current pixel row; values >= 480 are blanking/underflow
- frame_tick  in  1  one-clk pulse per frame, from game logic
- wr_en  in  1  board write strobe, one clk
- wr_col  in  6  write cell column, 0..COLS-1
- wr_row  in  5  write cell row, 0..ROWS-1
- wr_code  in  2  cell code: 0 empty, 1 body, 2 head, 3 food
- clear_req  in  1  one-clk pulse; request to clear the whole board
- busy  out  1  high while a clear sweep runs
- new_data  out  12  registered RGB {r[3:0],g[3:0],b[3:0]}

Behaviour:
- Reset (rst_n low, asynchronous): new_data=12'h000, busy=0, FSM=IDLE, blink counter=0, blink phase=0, pipeline valid bits=0. Board RAM contents are not reset.
- Pipeline, 3 clk latency from pos_x/pos_y to new_data:
  - S0: register col=pos_x>>CELL_SHIFT and row=pos_y>>CELL_SHIFT, in_range=(pos_x<640)&&(pos_y<480), plus the low CELL_SHIFT bits of pos_x/pos_y.
  - S1: synchronous RAM read at addr=row*COLS+col. This is 11 bits, computed as (row<<5)+(row<<3)+col for COLS=40. No multiplier.
  - S2: colour map into new_data.
- Colour map:
  - !in_range -> C_BG.
  - code 0 -> C_BG; code 1 -> C_BODY; code 2 -> C_HEAD.
  - code 3 -> C_FOOD when blink phase=0, C_BG when blink phase=1.
- Blink: counter increments on frame_tick. When it reaches BLINK_FRAMES-1 with a frame_tick, it wraps to 0 and toggles the phase.
- Write port: single RAM write per clk when wr_en=1 && state==IDLE && wr_col<COLS && wr_row<ROWS. Otherwise the write is silently dropped.
- Read/write collision on the same address: the read returns the old data (read-first).
- FSM:
  - IDLE: clear_req=1 -> CLEAR, with clear_addr=0 and busy=1 on the next clk.
  - CLEAR: write code 0 at clear_addr each clk and increment it. When clear_addr==COLS*ROWS-1 is written -> IDLE, with busy=0 on the following clk. The sweep takes 1200 clk.
  - clear_req during CLEAR is ignored; there is no restart.
  - wr_en coincident with clear_req in IDLE: the write is dropped and the clear wins.
  - Display reads continue during CLEAR and show a partially cleared board.
- Reset mid-CLEAR: FSM returns to IDLE and busy=0. The RAM is left partially cleared; the game logic must re-issue clear_req.

Optional Feature:
- GRID_LINES_EN defined: in S2, an in-range pixel in an empty cell (code 0) whose low CELL_SHIFT bits of x or of y are 0 outputs C_GRID instead of C_BG. Non-empty cells are unaffected.
- GRID_LINES_EN undefined: no grid logic and no stored low bits. Empty cells are solid C_BG.

Test Plan:
- Reset, then hold pos=(0,0) -> new_data=12'h000, busy=0. After clear_req, busy stays high exactly 1200 clk. Afterwards every cell reads C_BG.
- Write (col 5, row 3, code 2), then drive pos=(85,50) -> new_data=12'hFF0 exactly 3 clk after pos is applied. pos=(79,50), which is col 4, -> 12'h000.
- Write (col 39, row 29, code 1) and pos=(639,479) -> 12'h0F0. pos=(640,10) or pos=(10,1000) (underflow) -> 12'h000.
- Food at (0,0) with BLINK_FRAMES=15:
  - pos=(3,3) -> 12'hF00 for frame_ticks 1..14.
  - 12'h000 after the 15th tick.
  - 12'hF00 again after the 30th tick.
- wr_en during CLEAR and wr_col=40 in IDLE -> both dropped, cell content unchanged. clear_req while busy -> busy still drops after 1200 clk from the first request.
- With GRID_LINES_EN, empty cell: pos=(16,5) -> 12'h222, pos=(17,5) -> 12'h000. Body cell at (1,0), pos=(16,5) -> 12'h0F0.
